// File: rtl/dig_leds_mux.sv
// dig_leds_mux: memory-mapped seven-segment scan driver.
// Four bus registers (DATA, DP, BLANK, CTRL) drive a time-multiplexed
// digit scan with 16-level brightness PWM, whole-display blink and
// selectable pin polarity. Pin outputs are registered.
module dig_leds_mux #(
   parameter int          NDIG       = 8,
   parameter int          SCAN_DIV   = 100,
   parameter int          BLINK_DIV  = 5_000_000,
   parameter bit          ACTIVE_LOW = 1'b0,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000
) (
   input  logic            dig_clk,
   input  logic            dig_rst_n,
   input  logic [31:0]     dig_addr,
   input  logic            dig_we,
   input  logic [31:0]     dig_wdata,
   output logic [31:0]     dig_rdata,
   output logic [NDIG-1:0] dig_en,
   output logic [7:0]      dig_dn
);

   localparam int IDX_W   = (NDIG > 1)      ? $clog2(NDIG)      : 1;
   localparam int SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NDIG - 1);
   localparam logic [SCAN_W-1:0]  SCAN_LOAD  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_DIV - 1);

   // Polarity masks: XORed into the registered pins, reset values included.
   localparam logic [NDIG-1:0] EN_POL = {NDIG{ACTIVE_LOW}};
   localparam logic [7:0]      DN_POL = {8{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      REG_DATA  = 2'd0,
      REG_DP    = 2'd1,
      REG_BLANK = 2'd2,
      REG_CTRL  = 2'd3
   } reg_sel_e;

   // Bus decode; byte-lane bits of the address play no part.
   logic     hit;
   reg_sel_e sel;
   logic     wr;
   logic     addr_lsb_unused;

   assign hit             = (dig_addr[31:4] == BASE_ADDR[31:4]);
   assign sel             = reg_sel_e'(dig_addr[3:2]);
   assign wr              = dig_we & hit;
   assign addr_lsb_unused = ^dig_addr[1:0];

   // Programmable state
   logic [31:0]     data_q;
   logic [NDIG-1:0] dp_q;
   logic [NDIG-1:0] blank_q;
   logic            ctrl_en_q;
   logic            ctrl_blink_q;
   logic [3:0]      bright_q;

   // Scan / PWM / blink timing state
   logic [SCAN_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         pwm_q;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_ph_q;

   // Per-digit views widened to the full 8-digit space for uniform indexing.
   logic [7:0]      dp_ext;
   logic [7:0]      blank_ext;
   logic [7:0][3:0] data_nib;
   logic [2:0]      cur;

   assign dp_ext    = 8'(dp_q);
   assign blank_ext = 8'(blank_q);
   assign data_nib  = data_q;
   assign cur       = 3'(idx);

   function automatic logic [6:0] hex_font(input logic [3:0] v);
      case (v)
         4'h0: hex_font = 7'h3F;
         4'h1: hex_font = 7'h06;
         4'h2: hex_font = 7'h5B;
         4'h3: hex_font = 7'h4F;
         4'h4: hex_font = 7'h66;
         4'h5: hex_font = 7'h6D;
         4'h6: hex_font = 7'h7D;
         4'h7: hex_font = 7'h07;
         4'h8: hex_font = 7'h7F;
         4'h9: hex_font = 7'h6F;
         4'hA: hex_font = 7'h77;
         4'hB: hex_font = 7'h7C;
         4'hC: hex_font = 7'h39;
         4'hD: hex_font = 7'h5E;
         4'hE: hex_font = 7'h79;
         4'hF: hex_font = 7'h71;
      endcase
   endfunction

   // Register file: a bus write to a hit address updates the selected register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge dig_clk or negedge dig_rst_n) begin
      if (!dig_rst_n) begin
         data_q       <= '0;
         dp_q         <= '0;
         blank_q      <= '0;
         ctrl_en_q    <= 1'b1;
         ctrl_blink_q <= 1'b0;
         bright_q     <= 4'hF;
      end else if (wr) begin
         case (sel)
            REG_DATA:  data_q  <= dig_wdata;
            REG_DP:    dp_q    <= dig_wdata[NDIG-1:0];
            REG_BLANK: blank_q <= dig_wdata[NDIG-1:0];
            REG_CTRL: begin
               ctrl_en_q    <= dig_wdata[0];
               ctrl_blink_q <= dig_wdata[1];
               bright_q     <= dig_wdata[7:4];
            end
         endcase
      end
   end

   // Readback mux: unimplemented bits and non-hitting addresses read zero.
   // NOTE: a default is assigned first so no path leaves dig_rdata unassigned (no latch).
   always_comb begin
      dig_rdata = '0;
      if (hit) begin
         case (sel)
            REG_DATA:  dig_rdata = data_q;
            REG_DP:    dig_rdata = {24'h0, dp_ext};
            REG_BLANK: dig_rdata = {24'h0, blank_ext};
            REG_CTRL:  dig_rdata = {24'h0, bright_q, 2'b00, ctrl_blink_q, ctrl_en_q};
         endcase
      end
   end

   // Digit scan: dwell SCAN_DIV cycles per digit, index wraps at NDIG-1.
   always_ff @(posedge dig_clk or negedge dig_rst_n) begin
      if (!dig_rst_n) begin
         scan_cnt <= SCAN_LOAD;
         idx      <= '0;
      end else if (scan_cnt == '0) begin
         scan_cnt <= SCAN_LOAD;
         idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt - 1'b1;
      end
   end

   // Free-running brightness PWM phase, wraps 15 -> 0.
   always_ff @(posedge dig_clk or negedge dig_rst_n) begin
      if (!dig_rst_n) pwm_q <= 4'h0;
      else            pwm_q <= pwm_q + 1'b1;
   end

   // Blink half-period timer; runs regardless of the BLINK control bit.
   always_ff @(posedge dig_clk or negedge dig_rst_n) begin
      if (!dig_rst_n) begin
         blink_cnt  <= BLINK_LOAD;
         blink_ph_q <= 1'b0;
      end else if (blink_cnt == '0) begin
         blink_cnt  <= BLINK_LOAD;
         blink_ph_q <= ~blink_ph_q;
      end else begin
         blink_cnt <= blink_cnt - 1'b1;
      end
   end

   // Lit decision and the pin pattern for the digit currently scanned.
   logic            lit;
   logic [NDIG-1:0] en_next;
   logic [7:0]      dn_next;

   always_comb begin
      en_next = '0;
      dn_next = '0;
      lit = ctrl_en_q & ~blank_ext[cur] & (pwm_q <= bright_q) & ~(ctrl_blink_q & blink_ph_q);
      if (lit) begin
         en_next[idx] = 1'b1;
         dn_next      = {dp_ext[cur], hex_font(data_nib[cur])};
      end
   end

   // Registered pins with polarity applied last.
   always_ff @(posedge dig_clk or negedge dig_rst_n) begin
      if (!dig_rst_n) begin
         dig_en <= EN_POL;
         dig_dn <= DN_POL;
      end else begin
         dig_en <= en_next ^ EN_POL;
         dig_dn <= dn_next ^ DN_POL;
      end
   end

endmodule

// File: tb/tb_dig_leds_mux.sv
// tb_dig_leds_mux: directed bench for dig_leds_mux.
// Two instances share clock, reset and bus: an 8-digit active-high one and a
// 3-digit active-low one, both with SCAN_DIV=4 and BLINK_DIV=8. Expected pin
// values come from the cycle count since reset release: output after edge k
// shows slot (k-1)/4, pwm phase (k-1)%16 and blink phase ((k-1)/8)%2.
module tb_dig_leds_mux;

   localparam logic [31:0] BASE    = 32'hFFFF_F000;
   localparam logic [31:0] A_DATA  = BASE + 32'h0;
   localparam logic [31:0] A_DP    = BASE + 32'h4;
   localparam logic [31:0] A_BLANK = BASE + 32'h8;
   localparam logic [31:0] A_CTRL  = BASE + 32'hC;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata8, rdata3;
   logic [7:0]  en8;
   logic [2:0]  en3;
   logic [7:0]  dn8, dn3;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   logic [7:0] exp_dn [8];

   dig_leds_mux #(.NDIG(8), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1'b0), .BASE_ADDR(BASE)) dut8 (
      .dig_clk(clk), .dig_rst_n(rst_n), .dig_addr(addr), .dig_we(we),
      .dig_wdata(wdata), .dig_rdata(rdata8), .dig_en(en8), .dig_dn(dn8)
   );

   dig_leds_mux #(.NDIG(3), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1'b1), .BASE_ADDR(BASE)) dut3 (
      .dig_clk(clk), .dig_rst_n(rst_n), .dig_addr(addr), .dig_we(we),
      .dig_wdata(wdata), .dig_rdata(rdata3), .dig_en(en3), .dig_dn(dn3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release.
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   function automatic int slot(input int nd);
      return ((cyc - 1) / 4) % nd;
   endfunction

   function automatic int pwm_o();
      return (cyc - 1) % 16;
   endfunction

   function automatic int ph_o();
      return ((cyc - 1) / 8) % 2;
   endfunction

   function automatic logic [7:0] oh8(input int s);
      return 8'(32'd1 << s);
   endfunction

   function automatic logic [2:0] oh3n(input int s);
      return 3'(~(32'd1 << s));
   endfunction

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [31:0] a,
                           input logic [31:0] exp8, input logic [31:0] exp3);
      addr = a;
      #1;
      check({tag, "_rd8"}, rdata8, exp8);
      check({tag, "_rd3"}, rdata3, exp3);
   endtask

   task automatic wait_slot(input int nd, input int d);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (slot(nd) == d) found = 1'b1;
      end
      check("slot_reached", 32'(found), 32'd1);
   endtask

   task automatic check_frame8(input string tag);
      for (int d = 0; d < 8; d++) begin
         wait_slot(8, d);
         check($sformatf("%s_en%0d", tag, d), en8, oh8(d));
         check($sformatf("%s_dn%0d", tag, d), dn8, exp_dn[d]);
      end
   endtask

   initial begin
      int lit_cnt;
      rst_n = 1'b0;
      we    = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;

      // Reset state of the pins
      repeat (3) @(negedge clk);
      check("rst_en8", en8, 8'h00);
      check("rst_dn8", dn8, 8'h00);
      check("rst_en3", en3, 3'b111);
      check("rst_dn3", dn3, 8'hFF);

      // Scan after release: one-hot steps every 4 cycles, digit shows 0
      rst_n = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         check("scan_en8", en8, oh8(slot(8)));
         check("scan_dn8", dn8, 8'h3F);
         check("scan_en3", en3, oh3n(slot(3)));
         check("scan_dn3", dn3, 8'hC0);
      end
      bus_read("ctrl_rst", A_CTRL, 32'h0000_00F1, 32'h0000_00F1);
      bus_read("data_rst", A_DATA, 32'h0, 32'h0);

      // Data and decimal points
      bus_write(A_DATA, 32'h89AB_CDEF);
      bus_write(A_DP, 32'h0000_0001);
      bus_read("data_wr", A_DATA, 32'h89AB_CDEF, 32'h89AB_CDEF);
      bus_read("dp_wr", A_DP, 32'h1, 32'h1);
      repeat (2) @(negedge clk);
      exp_dn[0] = 8'hF1; exp_dn[1] = 8'h79; exp_dn[2] = 8'h5E; exp_dn[3] = 8'h39;
      exp_dn[4] = 8'h7C; exp_dn[5] = 8'h77; exp_dn[6] = 8'h6F; exp_dn[7] = 8'h7F;
      check_frame8("hexhi");
      wait_slot(3, 0);
      check("al_slot0_en", en3, 3'b110);
      check("al_slot0_dn", dn3, 8'h0E);
      wait_slot(3, 2);
      check("al_slot2_en", en3, 3'b011);
      check("al_slot2_dn", dn3, 8'hA1);

      bus_write(A_DATA, 32'h7654_3210);
      repeat (2) @(negedge clk);
      exp_dn[0] = 8'hBF; exp_dn[1] = 8'h06; exp_dn[2] = 8'h5B; exp_dn[3] = 8'h4F;
      exp_dn[4] = 8'h66; exp_dn[5] = 8'h6D; exp_dn[6] = 8'h7D; exp_dn[7] = 8'h07;
      check_frame8("hexlo");

      // Blanking at full brightness
      bus_write(A_BLANK, 32'h0000_0002);
      repeat (2) @(negedge clk);
      wait_slot(8, 1);
      check("blank_en8", en8, 8'h00);
      check("blank_dn8", dn8, 8'h00);
      wait_slot(8, 2);
      check("unblank_en8", en8, 8'h04);
      check("unblank_dn8", dn8, 8'h5B);
      wait_slot(3, 1);
      check("blank_en3", en3, 3'b111);
      check("blank_dn3", dn3, 8'hFF);

      // Minimum brightness: lit only when the pwm phase is 0
      bus_write(A_CTRL, 32'h0000_0001);
      bus_read("ctrl_b0", A_CTRL, 32'h1, 32'h1);
      repeat (2) @(negedge clk);
      lit_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         check("b0_en8", en8, (pwm_o() == 0 && slot(8) != 1) ? oh8(slot(8)) : 8'h00);
         check("b0_en3", en3, (pwm_o() == 0 && slot(3) != 1) ? oh3n(slot(3)) : 3'b111);
         if (en8 != 8'h00) lit_cnt++;
      end
      check("b0_duty", lit_cnt, 4);

      // Blink: 8 cycles lit, 8 dark
      bus_write(A_BLANK, 32'h0);
      bus_write(A_CTRL, 32'h0000_00F3);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         check("blink_en8", en8, (ph_o() == 0) ? oh8(slot(8)) : 8'h00);
         check("blink_en3", en3, (ph_o() == 0) ? oh3n(slot(3)) : 3'b111);
      end

      // Disable: dark from the second cycle after the write
      bus_write(A_CTRL, 32'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("off_en8", en8, 8'h00);
         check("off_dn8", dn8, 8'h00);
         check("off_en3", en3, 3'b111);
         check("off_dn3", dn3, 8'hFF);
      end

      // Blink off then on again: the phase keeps running meanwhile
      bus_write(A_CTRL, 32'h0000_00F1);
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("noblink_en8", en8, oh8(slot(8)));
      end
      bus_write(A_CTRL, 32'h0000_00F3);
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check("reblink_en8", en8, (ph_o() == 0) ? oh8(slot(8)) : 8'h00);
      end

      // Unimplemented bits read zero
      bus_write(A_DP, 32'hFFFF_FFFF);
      bus_read("dp_ff", A_DP, 32'hFF, 32'h7);
      bus_write(A_BLANK, 32'hFFFF_FFFF);
      bus_read("blank_ff", A_BLANK, 32'hFF, 32'h7);
      bus_write(A_CTRL, 32'hFFFF_FFFF);
      bus_read("ctrl_ff", A_CTRL, 32'hF3, 32'hF3);
      bus_write(A_CTRL, 32'h0000_00F1);
      bus_write(A_BLANK, 32'h0);
      bus_write(A_DP, 32'h0);

      // Address decode
      bus_write(BASE + 32'h10, 32'hDEAD_BEEF);
      bus_read("miss_wr", A_DATA, 32'h7654_3210, 32'h7654_3210);
      bus_read("miss_rd", BASE + 32'h10, 32'h0, 32'h0);
      bus_read("lsb_ign", BASE + 32'h3, 32'h7654_3210, 32'h7654_3210);
      bus_read("hi_miss", 32'h0000_000C, 32'h0, 32'h0);

      // Asynchronous reset mid-slot, write attempt while held
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_en8", en8, 8'h00);
      check("arst_dn8", dn8, 8'h00);
      check("arst_en3", en3, 3'b111);
      check("arst_dn3", dn3, 8'hFF);
      bus_read("arst_data", A_DATA, 32'h0, 32'h0);
      bus_read("arst_ctrl", A_CTRL, 32'hF1, 32'hF1);
      addr  = A_DATA;
      wdata = 32'h0000_1234;
      we    = 1'b1;
      repeat (2) @(negedge clk);
      we = 1'b0;
      bus_read("rstwr", A_DATA, 32'h0, 32'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("restart_en8", en8, (k <= 4) ? 8'h01 : 8'h02);
         check("restart_dn8", dn8, 8'h3F);
         check("restart_en3", en3, oh3n(slot(3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
